// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, signed or unsigned, fixed latency
// Ports: Clk clock; Rst_n async active-low reset; Start division request;
//        Signed selects two's-complement operands; Dividend/Divisor operands;
//        Busy high in CALC/FIX; Done one-cycle result strobe;
//        Quotient/Remainder registered results (LO/HI); DivZero zero-divisor flag.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] q_sh, r_sh, d_mag, dvd, a_mag_in, b_mag_in;
   logic             a_neg, b_neg, a_neg_in, b_neg_in, accept;
   logic [WIDTH:0]   sub;
   assign Busy     = state == CALC || state == FIX;
   assign Done     = state == DONE;
   assign accept   = Start && (state == IDLE || state == DONE);
   assign a_neg_in = Signed & Dividend[WIDTH-1];
   assign b_neg_in = Signed & Divisor[WIDTH-1];
   assign a_mag_in = a_neg_in ? -Dividend : Dividend;
   assign b_mag_in = b_neg_in ? -Divisor : Divisor;
   // partial remainder stays below the divisor, so the shifted value minus the
   // divisor always fits WIDTH+1 signed bits and the top bit is the borrow
   assign sub = {r_sh, q_sh[WIDTH-1]} - {1'b0, d_mag};
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         q_sh      <= '0;
         r_sh      <= '0;
         d_mag     <= '0;
         dvd       <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivZero   <= 1'b0;
      end else if (accept) begin
         state <= CALC;
         cnt   <= CW'(WIDTH);
         q_sh  <= a_mag_in;
         r_sh  <= '0;
         d_mag <= b_mag_in;
         dvd   <= Dividend;
         a_neg <= a_neg_in;
         b_neg <= b_neg_in;
      end else if (state == CALC) begin
         q_sh  <= {q_sh[WIDTH-2:0], ~sub[WIDTH]};
         r_sh  <= sub[WIDTH] ? {r_sh[WIDTH-2:0], q_sh[WIDTH-1]} : sub[WIDTH-1:0];
         cnt   <= cnt - CW'(1);
         state <= cnt == CW'(1) ? FIX : CALC;
      end else if (state == FIX) begin
         // most-negative / -1 needs no special case: magnitudes give 2^(W-1) rem 0
         Quotient  <= d_mag == '0 ? '1 : (a_neg ^ b_neg) ? -q_sh : q_sh;
         Remainder <= d_mag == '0 ? dvd : a_neg ? -r_sh : r_sh;
         DivZero   <= d_mag == '0;
         state     <= DONE;
      end else if (state == DONE)
         state <= IDLE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model
module tb_seq_divider;
   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0;
   logic        Signed = 1'b0;
   logic [31:0] Dividend = '0;
   logic [31:0] Divisor = '0;
   logic        Busy, Done, DivZero;
   logic [31:0] Quotient, Remainder;
   int          tests = 0;
   int          fails = 0;
   int          lat, busy, seen;
   logic [31:0] mq, mr, ra, rb;
   logic        mdz, rs;

   seq_divider #(.WIDTH(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Signed(Signed),
      .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
      .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // truncating division from plain integer arithmetic
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
      int sa, sb;
      sa = a;
      sb = b;
      dz = b == 0;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // called at a negedge; Start is seen by the next rising edge (latency edge 1)
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      Dividend = a;
      Divisor  = b;
      Signed   = s;
      Start    = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // latency counts rising edges from the Start-sampling edge (inclusive) to Done
   task automatic wait_done(inout int l, output int b);
      b = 0;
      while (!Done && l < 100) begin
         if (Busy) b++;
         @(posedge Clk);
         l++;
         @(negedge Clk);
      end
   endtask

   task automatic result_chk(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dz);
      chk({tag, " latency"}, lat, 34);
      chk({tag, " quotient"}, Quotient, q);
      chk({tag, " remainder"}, Remainder, r);
      chk({tag, " divzero"}, {31'b0, DivZero}, {31'b0, dz});
      chk({tag, " busy at done"}, {31'b0, Busy}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] q, input logic [31:0] r, input logic dz);
      launch(a, b, s);
      lat = 1;
      wait_done(lat, busy);
      chk({tag, " busy cycles"}, busy, 33);
      result_chk(tag, q, r, dz);
      @(posedge Clk);
      @(negedge Clk);
      chk({tag, " done pulse width"}, {31'b0, Done}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      chk("reset busy", {31'b0, Busy}, 32'd0);
      chk("reset done", {31'b0, Done}, 32'd0);
      chk("reset quotient", Quotient, 32'd0);
      chk("reset remainder", Remainder, 32'd0);
      chk("reset divzero", {31'b0, DivZero}, 32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);

      run("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      run("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
      run("u/0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      run("s/0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      run("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
      run("u min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);

      // Start held high with changing operands while busy
      Dividend = 32'd1000;
      Divisor  = 32'd33;
      Signed   = 1'b0;
      Start    = 1'b1;
      @(posedge Clk);
      lat = 1;
      repeat (10) begin
         @(negedge Clk);
         Dividend = $urandom;
         Divisor  = $urandom_range(1, 99);
         Signed   = 1'b1;
         @(posedge Clk);
         lat++;
      end
      @(negedge Clk);
      Start = 1'b0;
      wait_done(lat, busy);
      result_chk("held start", 32'd30, 32'd10, 1'b0);
      @(posedge Clk);
      @(negedge Clk);
      chk("held start no restart", {31'b0, Busy}, 32'd0);

      // back-to-back: second Start presented during the DONE cycle
      launch(32'd500, 32'd9, 1'b0);
      lat = 1;
      wait_done(lat, busy);
      result_chk("b2b first", 32'd55, 32'd5, 1'b0);
      launch(32'hFFFF_FF9C, 32'd7, 1'b1);
      chk("b2b restarted busy", {31'b0, Busy}, 32'd1);
      lat = 1;
      wait_done(lat, busy);
      result_chk("b2b second", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      @(negedge Clk);

      // random operands against the model
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rs = 1'($urandom_range(0, 1));
         case (i % 4)
            0: rb = $urandom_range(1, 15);
            1: rb = $urandom >> $urandom_range(0, 31);
            2: rb = -($urandom_range(1, 300));
            default: rb = $urandom;
         endcase
         model(ra, rb, rs, mq, mr, mdz);
         run($sformatf("rand%0d", i), ra, rb, rs, mq, mr, mdz);
      end

      // reset 10 cycles into CALC
      launch(32'd77777, 32'd3, 1'b0);
      repeat (9) @(negedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      chk("mid reset busy", {31'b0, Busy}, 32'd0);
      chk("mid reset done", {31'b0, Done}, 32'd0);
      chk("mid reset quotient", Quotient, 32'd0);
      chk("mid reset remainder", Remainder, 32'd0);
      chk("mid reset divzero", {31'b0, DivZero}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      seen = 0;
      repeat (50) begin
         @(negedge Clk);
         if (Done) seen++;
      end
      chk("no done after reset", seen, 0);
      chk("quotient held after reset", Quotient, 32'd0);
      run("first after reset", 32'd77777, 32'd3, 1'b0, 32'd25925, 32'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
